// File: rtl/cmp_run_monitor_if.sv
// Sample-stream and event handshake bundle for cmp_run_monitor.
// Modports: slave is the monitor, master is whoever drives samples and consumes events.
interface cmp_run_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_c;
    logic             in_ready;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_index;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] sample_count;

    modport slave (
        input  in_valid,
        input  in_c,
        input  evt_ready,
        output in_ready,
        output evt_valid,
        output evt_index,
        output hit_count,
        output sample_count
    );

    modport master (
        output in_valid,
        output in_c,
        output evt_ready,
        input  in_ready,
        input  evt_valid,
        input  evt_index,
        input  hit_count,
        input  sample_count
    );
endinterface

// File: rtl/cmp_run_monitor.sv
// Run monitor for the comparator result stream: counts samples/hits and reports RUN_LEN consecutive hits.
// Optional macro CMP_MON_SAT_EN makes the sample and hit counters saturate instead of wrapping.
module cmp_run_monitor #(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    cmp_run_monitor_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int               RUN_W    = 8;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef CMP_MON_SAT_EN
        if (v == CNT_MAX) begin
            cnt_inc = v;
        end else begin
            cnt_inc = v + CNT_ONE;
        end
`else
        cnt_inc = v + CNT_ONE;
`endif
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RUN_W-1:0]   r_run_cnt;
    logic [RUN_W-1:0]   w_run_nxt;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   w_sample_nxt;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   w_hit_nxt;
    logic [CNT_W-1:0]   r_evt_index;
    logic [CNT_W-1:0]   w_evt_index_nxt;
    logic               r_evt_valid;
    logic               w_evt_valid_nxt;
    logic               r_in_ready;
    logic               w_in_ready_nxt;
    logic               w_accept;

    // in_ready is a flop, so acceptance never depends combinationally on downstream.
    assign w_accept = bus.in_valid & r_in_ready;

    // Next-state and datapath decode; clear dominates any accept or handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run_cnt;
        w_sample_nxt    = r_sample_cnt;
        w_hit_nxt       = r_hit_cnt;
        w_evt_index_nxt = r_evt_index;
        w_evt_valid_nxt = r_evt_valid;
        w_in_ready_nxt  = r_in_ready;
        if (clear) begin
            w_state_nxt     = ST_IDLE;
            w_run_nxt       = {RUN_W{1'b0}};
            w_sample_nxt    = CNT_ZERO;
            w_hit_nxt       = CNT_ZERO;
            w_evt_index_nxt = CNT_ZERO;
            w_evt_valid_nxt = 1'b0;
            w_in_ready_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_TRACK: begin
                    if (w_accept) begin
                        w_sample_nxt = cnt_inc(r_sample_cnt);
                        if (bus.in_c) begin
                            w_hit_nxt = cnt_inc(r_hit_cnt);
                            if (r_run_cnt == RUN_LAST) begin
                                w_evt_index_nxt = r_sample_cnt;
                                w_evt_valid_nxt = 1'b1;
                                w_run_nxt       = {RUN_W{1'b0}};
                                w_state_nxt     = ST_REPORT;
                                w_in_ready_nxt  = 1'b0;
                            end else begin
                                w_run_nxt   = r_run_cnt + RUN_ONE;
                                w_state_nxt = ST_TRACK;
                            end
                        end else begin
                            w_run_nxt   = {RUN_W{1'b0}};
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_REPORT: begin
                    if (bus.evt_ready) begin
                        w_evt_valid_nxt = 1'b0;
                        w_state_nxt     = ST_IDLE;
                        w_in_ready_nxt  = 1'b1;
                    end else begin
                        w_evt_valid_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_run_nxt       = {RUN_W{1'b0}};
                    w_evt_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, event payload and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt    <= {RUN_W{1'b0}};
            r_sample_cnt <= CNT_ZERO;
            r_hit_cnt    <= CNT_ZERO;
            r_evt_index  <= CNT_ZERO;
            r_evt_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_run_cnt    <= w_run_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_hit_cnt    <= w_hit_nxt;
            r_evt_index  <= w_evt_index_nxt;
            r_evt_valid  <= w_evt_valid_nxt;
            r_in_ready   <= w_in_ready_nxt;
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.evt_valid    = r_evt_valid;
    assign bus.evt_index    = r_evt_index;
    assign bus.hit_count    = r_hit_cnt;
    assign bus.sample_count = r_sample_cnt;

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: events are scoreboarded at the handshake, state is spot-checked.
module tb_cmp_run_monitor;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] hit;
        logic [7:0] smp;
    } evt_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    int   n_chk = 0;
    int   n_err = 0;
    int   m_chk = 0;
    int   m_err = 0;
    evt_t exp_q[$];
    evt_t mon_e;

    always #5 clk = ~clk;

    cmp_run_monitor_if #(.CNT_W(8)) bus   ();
    cmp_run_monitor_if #(.CNT_W(4)) bus_w ();
    cmp_run_monitor_if #(.CNT_W(8)) bus_1 ();

    cmp_run_monitor #(.RUN_LEN(3),   .CNT_W(8)) dut   (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus));
    cmp_run_monitor #(.RUN_LEN(255), .CNT_W(4)) dut_w (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_w));
    cmp_run_monitor #(.RUN_LEN(1),   .CNT_W(8)) dut_1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_1));

    // Scoreboard monitor: every completed handshake on the main DUT must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && !clear && bus.evt_valid && bus.evt_ready) begin
            m_chk++;
            if (exp_q.size() == 0) begin
                m_err++;
                $display("FAIL evt_unexpected: got index %0d hit %0d smp %0d, required no event",
                         bus.evt_index, bus.hit_count, bus.sample_count);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.evt_index, bus.hit_count, bus.sample_count} !== mon_e) begin
                    m_err++;
                    $display("FAIL evt_payload: got idx %0d hit %0d smp %0d, required idx %0d hit %0d smp %0d",
                             bus.evt_index, bus.hit_count, bus.sample_count, mon_e.idx, mon_e.hit, mon_e.smp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic ev,
                           input logic [7:0] idx, input logic [7:0] hit, input logic [7:0] smp);
        chk($sformatf("%s.in_ready", tag),     {31'd0, bus.in_ready},   {31'd0, rdy});
        chk($sformatf("%s.evt_valid", tag),    {31'd0, bus.evt_valid},  {31'd0, ev});
        chk($sformatf("%s.evt_index", tag),    {24'd0, bus.evt_index},  {24'd0, idx});
        chk($sformatf("%s.hit_count", tag),    {24'd0, bus.hit_count},  {24'd0, hit});
        chk($sformatf("%s.sample_count", tag), {24'd0, bus.sample_count}, {24'd0, smp});
    endtask

    task automatic step(input logic v, input logic c, input logic er);
        bus.in_valid  = v;
        bus.in_c      = c;
        bus.evt_ready = er;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_c       = 1'b0;
        bus.evt_ready  = 1'b0;
        bus_w.in_valid = 1'b0;
        bus_w.in_c     = 1'b0;
        bus_w.evt_ready = 1'b1;
        bus_1.in_valid = 1'b0;
        bus_1.in_c     = 1'b0;
        bus_1.evt_ready = 1'b1;

        #12;
        chk_out("reset", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run of three hits.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        exp_q.push_back({8'd2, 8'd3, 8'd3});
        step(1'b1, 1'b1, 1'b1);
        chk_out("basic", 1'b0, 1'b1, 8'd2, 8'd3, 8'd3);
        step(1'b0, 1'b0, 1'b1);
        chk_out("basic_ack", 1'b1, 1'b0, 8'd2, 8'd3, 8'd3);

        do_clear();
        chk_out("clear", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

        // Broken run: 1,1,0,1,1,1.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk_out("broken_mid", 1'b1, 1'b0, 8'd0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        exp_q.push_back({8'd5, 8'd5, 8'd6});
        step(1'b1, 1'b1, 1'b1);
        chk_out("broken", 1'b0, 1'b1, 8'd5, 8'd5, 8'd6);
        step(1'b0, 1'b0, 1'b1);
        chk_out("broken_ack", 1'b1, 1'b0, 8'd5, 8'd5, 8'd6);

        // Backpressure: event held for four cycles while upstream keeps offering hits.
        do_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        chk_out("bp_evt", 1'b0, 1'b1, 8'd2, 8'd3, 8'd3);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk_out($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 8'd2, 8'd3, 8'd3);
        end
        exp_q.push_back({8'd2, 8'd3, 8'd3});
        step(1'b1, 1'b1, 1'b1);
        chk_out("bp_ack", 1'b1, 1'b0, 8'd2, 8'd3, 8'd3);
        step(1'b1, 1'b1, 1'b1);
        chk_out("bp_resume", 1'b1, 1'b0, 8'd2, 8'd4, 8'd4);

        // Clear while an event is pending, with a simultaneous evt_ready.
        do_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        chk_out("clr_rep_evt", 1'b0, 1'b1, 8'd2, 8'd3, 8'd3);
        clear = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        clear = 1'b0;
        chk_out("clr_report", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b1);
        chk_out("clr_report_after", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

        // Asynchronous reset in the middle of a run.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk_out("pre_rst", 1'b1, 1'b0, 8'd0, 8'd2, 8'd2);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        exp_q.push_back({8'd2, 8'd3, 8'd3});
        step(1'b1, 1'b1, 1'b1);
        chk_out("post_rst", 1'b0, 1'b1, 8'd2, 8'd3, 8'd3);
        step(1'b0, 1'b0, 1'b1);

        // Narrow counters: 20 hits into CNT_W=4, RUN_LEN=255.
        bus_w.in_valid = 1'b1;
        bus_w.in_c     = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus_w.in_valid = 1'b0;
`ifdef CMP_MON_SAT_EN
        chk("width.hit_count",    {28'd0, bus_w.hit_count},    32'd15);
        chk("width.sample_count", {28'd0, bus_w.sample_count}, 32'd15);
`else
        chk("width.hit_count",    {28'd0, bus_w.hit_count},    32'd4);
        chk("width.sample_count", {28'd0, bus_w.sample_count}, 32'd4);
`endif
        chk("width.evt_valid", {31'd0, bus_w.evt_valid}, 32'd0);
        chk("width.in_ready",  {31'd0, bus_w.in_ready},  32'd1);

        // RUN_LEN=1: every accepted hit is an event, straight from IDLE.
        bus_1.in_valid = 1'b1;
        bus_1.in_c     = 1'b1;
        @(posedge clk);
        #1;
        chk("rl1.evt_valid0", {31'd0, bus_1.evt_valid}, 32'd1);
        chk("rl1.in_ready0",  {31'd0, bus_1.in_ready},  32'd0);
        chk("rl1.evt_index0", {24'd0, bus_1.evt_index}, 32'd0);
        @(posedge clk);
        #1;
        chk("rl1.evt_valid1",    {31'd0, bus_1.evt_valid},    32'd0);
        chk("rl1.sample_count1", {24'd0, bus_1.sample_count}, 32'd1);
        bus_1.in_c = 1'b0;
        @(posedge clk);
        #1;
        chk("rl1.sample_count2", {24'd0, bus_1.sample_count}, 32'd2);
        chk("rl1.evt_valid2",    {31'd0, bus_1.evt_valid},    32'd0);
        bus_1.in_c = 1'b1;
        @(posedge clk);
        #1;
        bus_1.in_valid = 1'b0;
        chk("rl1.evt_valid3", {31'd0, bus_1.evt_valid}, 32'd1);
        chk("rl1.evt_index3", {24'd0, bus_1.evt_index}, 32'd2);
        chk("rl1.hit_count3", {24'd0, bus_1.hit_count}, 32'd2);

        @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk + m_chk, n_err + m_err);
        $finish;
    end

endmodule

// File: doc/cmp_run_monitor.md
# cmp_run_monitor

Sequential monitor that sits directly downstream of the 2-bit magnitude comparator and consumes its 1-bit result `c` as a sample stream. It counts accepted samples and hits (`c`=1). When it sees RUN_LEN consecutive hits, it raises an event that is held under a valid/ready handshake. While an event is pending, the monitor back-pressures its upstream.

## Interface
Parameters:
- RUN_LEN, 3, number of consecutive accepted `c`=1 samples that constitutes an event (legal 1..255)
- CNT_W, 8, width of the sample, hit and index counters (legal 2..32)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous clear, highest priority after reset
- in_valid  input  1  `in_c` carries a comparator result this cycle
- in_c  input  1  comparator output (1 = comparison true)
- in_ready  output  1  monitor accepts a sample this cycle
- evt_valid  output  1  run event pending
- evt_ready  input  1  downstream consumes the event
- evt_index  output  CNT_W  sample index (0-based) of the sample that completed the run
- hit_count  output  CNT_W  number of accepted samples with `in_c`=1
- sample_count  output  CNT_W  number of accepted samples

## Operation
- accept = in_valid & in_ready. No sample is consumed otherwise.
- The FSM has three states: IDLE (run_cnt = 0), TRACK (0 < run_cnt < RUN_LEN), REPORT (event pending).
- In IDLE and TRACK, in_ready = 1. In REPORT, in_ready = 0. in_ready is decoded from the state register only and has no combinational path from any input.
- Accept with in_c=1:
  - sample_count and hit_count increment.
  - If run_cnt == RUN_LEN-1: load evt_index ← current sample_count (pre-increment value), set evt_valid, clear run_cnt, and go to REPORT.
  - Otherwise run_cnt increments and the FSM goes to TRACK.
- Accept with in_c=0: sample_count increments, run_cnt ← 0, and the FSM goes to IDLE.
- Runs are non-overlapping. After an event, the run count restarts from zero.
- REPORT: all counters are frozen. On evt_valid & evt_ready, evt_valid clears and the FSM goes to IDLE. evt_index holds its last value until the next event.
- clear: zero all counters, run_cnt and evt_index, drop evt_valid, and go to IDLE. This applies in every state, including REPORT (the pending event is aborted), and overrides a simultaneous accept or handshake.
- Reset values: in_ready=1, evt_valid=0, evt_index=0, hit_count=0, sample_count=0, state IDLE.
- If reset is asserted mid-run or in REPORT, all outputs go to their reset values immediately (asynchronous). Operation resumes on the first clock edge after deassertion.

## Timing
- All outputs are registered.
- Counters update on the edge that accepts the sample, so they are visible in the following cycle.
- evt_valid rises in the cycle after the accepting edge of the RUN_LEN-th consecutive hit. in_ready falls in that same cycle.
- Event handshake completes on the edge where evt_valid & evt_ready. in_ready is 1 in the next cycle.
- With evt_ready tied high, each event costs exactly one REPORT cycle in which no sample is accepted.
- RUN_LEN=1: every accepted hit produces an event, and the FSM goes directly from IDLE to REPORT.

## Configuration
- CMP_MON_SAT_EN defined: sample_count and hit_count saturate at all-ones and hold there; evt_index takes the saturated value.
- CMP_MON_SAT_EN undefined: both counters wrap modulo 2^CNT_W.
- In both cases, run detection is unaffected by counter saturation or wrap.

## Test plan
- Basic run (RUN_LEN=3, evt_ready=1): in_c = 1,1,1 on consecutive cycles → evt_valid=1 for one cycle, evt_index=2, hit_count=3, sample_count=3, in_ready=0 during that cycle.
- Broken run: in_c = 1,1,0,1,1,1 → a single event with evt_index=5, hit_count=5, sample_count=6. There is no event after the second sample.
- Backpressure: complete a run with evt_ready=0 for 4 cycles while in_valid=1 and in_c=1 → in_ready=0, counters frozen, evt_valid held. Then raise evt_ready → handshake, in_ready=1 on the next cycle, and counting resumes.
- Counter width (CNT_W=4, RUN_LEN=255, 20 accepted hits):
  - With CMP_MON_SAT_EN: hit_count=15, sample_count=15.
  - Without CMP_MON_SAT_EN: hit_count=4, sample_count=4.
- Clear in REPORT: drive an event and hold evt_ready=0, then pulse clear for one cycle → next cycle evt_valid=0, all counters 0, in_ready=1. A simultaneous evt_ready=1 has no effect.
- Async reset mid-run: after in_c=1,1, assert rst_n=0 between clock edges → outputs return to reset values immediately. After release, in_c=1,1,1 → event with evt_index=2.
